snake_lap_ctrl: RTL and testbench
=================================

Name: snake_lap_ctrl

Overview:
- Lap counter and run controller for the 7-segment snake display.
- Counts completed passes of the snake pattern in either direction and presents the count as packed BCD for the digit drivers.
- Raises run_stop after a programmable number of laps.
- Sits between the pattern-position counter (ptn_cnt, ptn_tick) and the 7-segment decoder/scan logic.

Parameters:
- PTN_LEN, 8, number of pattern positions per lap; positions 0..PTN_LEN-1.
- PTN_W, 5, width of ptn_cnt; 2^PTN_W >= PTN_LEN.
- DIGITS, 2, number of BCD digits in lap_bcd.
- MAX_LAPS, 9, terminal lap count, 1..10^DIGITS-1; larger values are an elaboration error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; a high sample in IDLE or DONE begins a new run.
- clear  in  1  synchronous abort to IDLE; has priority over start.
- updn  in  1  pattern direction: 1 = up (0 toward PTN_LEN-1), 0 = down.
- ptn_tick  in  1  one-cycle strobe; ptn_cnt is valid and has just advanced.
- ptn_cnt  in  PTN_W  current pattern position.
- lap_bcd  out  4*DIGITS  packed BCD lap count; digit 0 in bits [3:0].
- lap_pulse  out  1  one-cycle strobe on each counted lap.
- busy  out  1  high in RUN.
- run_stop  out  1  high in DONE.

Behaviour:
- Reset (async): state=IDLE, lap_bcd=0, lap_pulse=0, busy=0, run_stop=0.
- FSM states: IDLE, RUN, DONE. Per-edge priority: clear > start > lap event.
- IDLE:
  - clear: stay IDLE.
  - start: go to RUN and load lap_bcd=0.
- RUN:
  - clear: go to IDLE; lap_bcd retained for display.
  - Otherwise a lap event increments the counter.
- DONE:
  - start (without clear): go to RUN, lap_bcd=0, run_stop deasserts on the same edge.
  - clear: go to IDLE; lap_bcd retained.
- Lap event (RUN only): ptn_tick=1 AND ((updn=1 AND ptn_cnt==PTN_LEN-1) OR (updn=0 AND ptn_cnt==0)).
  - Counted once per tick, never per cycle while ptn_cnt holds.
- updn is sampled together with the tick. A direction reversal mid-lap needs no special handling: the next end position reached in the current direction counts.
- ptn_cnt >= PTN_LEN never produces an event.
- Counting on the event edge: lap_bcd += 1 as a BCD increment with ripple carry (digit 9 -> 0 with carry to the next digit); lap_pulse=1 for exactly one cycle, registered on that same edge.
- Terminal count: when the incremented value equals MAX_LAPS, go to DONE on that same edge. run_stop=1 and busy=0 take effect from that edge; lap_pulse is still asserted for that lap.
- In DONE and IDLE, lap events are ignored; lap_bcd holds and lap_pulse stays 0.
- Output latency: all outputs are registered, 1 cycle after the qualifying input sample.
- busy and run_stop are never high together. lap_bcd never exceeds MAX_LAPS.
- rst asserted mid-run: immediate return to reset values; no partial count survives.
- start held high continuously: a single RUN entry. Start is re-sampled only in IDLE and DONE, so a held start re-arms immediately after DONE.

Optional Feature:
- Macro: SNAKE_LAP_WRAP_EN.
- Defined: reaching MAX_LAPS does not enter DONE. lap_bcd wraps to 0 on that edge, lap_pulse fires, state stays RUN, and run_stop is never asserted. DONE is unreachable; only clear or rst leaves RUN.
- Undefined: terminal-count behaviour exactly as in Behaviour.

Test Plan:
- Reset, start, updn=1, ptn_cnt stepping 0..7 with one ptn_tick per step: lap_bcd goes 0x00->0x01 on the tick at ptn_cnt=7; lap_pulse high 1 cycle; busy=1.
- ptn_cnt held at 7 for 5 cycles with a single tick: exactly one increment (lap_bcd=0x01), not five.
- updn=0, descending 7..0 for 9 laps, MAX_LAPS=9: lap_bcd=0x09, run_stop=1, busy=0 on the 9th lap edge. A further lap at 0 leaves lap_bcd=0x09 and lap_pulse=0.
- MAX_LAPS=12, DIGITS=2: lap 9->10 gives lap_bcd 0x09->0x10 (BCD carry); DONE at 0x12. Then start=1 gives RUN with lap_bcd=0x00.
- clear and start asserted together in DONE: state=IDLE, lap_bcd held at 0x09, run_stop=0, busy=0. rst pulsed mid-lap at lap 4 gives all outputs 0 immediately.
- SNAKE_LAP_WRAP_EN defined, MAX_LAPS=9: the 9th lap gives lap_bcd=0x00, lap_pulse=1, busy=1, run_stop stays 0; the 10th lap gives 0x01.

Source files
------------

// File: rtl/snake_lap_ctrl_if.sv
// ---------------------------------------------------------------------------
// snake_lap_ctrl_if : control/pattern inputs and lap outputs of snake_lap_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface snake_lap_ctrl_if #(
  parameter int PTN_W  = 5,
  parameter int DIGITS = 2
);
  logic                  start_i;
  logic                  clear_i;
  logic                  updn_i;
  logic                  ptn_tick_i;
  logic [PTN_W-1:0]      ptn_cnt_i;
  logic [4*DIGITS-1:0]   lap_bcd_o;
  logic                  lap_pulse_o;
  logic                  busy_o;
  logic                  run_stop_o;

  modport master (
    output start_i, clear_i, updn_i, ptn_tick_i, ptn_cnt_i,
    input  lap_bcd_o, lap_pulse_o, busy_o, run_stop_o
  );

  modport slave (
    input  start_i, clear_i, updn_i, ptn_tick_i, ptn_cnt_i,
    output lap_bcd_o, lap_pulse_o, busy_o, run_stop_o
  );
endinterface

`default_nettype wire

// File: rtl/snake_lap_ctrl.sv
// ---------------------------------------------------------------------------
// snake_lap_ctrl : BCD lap counter and run controller for the snake display.
// Optional macro SNAKE_LAP_WRAP_EN: wrap at MAX_LAPS instead of stopping.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snake_lap_ctrl #(
  parameter int PTN_LEN  = 8,
  parameter int PTN_W    = 5,
  parameter int DIGITS   = 2,
  parameter int MAX_LAPS = 9
) (
  input  wire logic        clk,
  input  wire logic        rst,
  snake_lap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  if (MAX_LAPS < 1 || MAX_LAPS > 10**DIGITS - 1) begin : g_bad_max_laps
    $error("snake_lap_ctrl: MAX_LAPS out of range for DIGITS");
  end

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int                  x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_LAPS);

  state_t               state_q;
  logic [4*DIGITS-1:0]  lap_bcd_q;
  logic                 lap_pulse_q;
  logic                 busy_q;
  logic                 run_stop_q;

  logic [4*DIGITS-1:0]  lap_inc_d;
  logic                 lap_evt;

  // Out-of-range positions can never equal either end, so they never count.
  assign lap_evt = bus.ptn_tick_i &&
                   (( bus.updn_i && (bus.ptn_cnt_i == PTN_W'(PTN_LEN - 1))) ||
                    (!bus.updn_i && (bus.ptn_cnt_i == '0)));

  always_comb begin
    logic carry;
    lap_inc_d = lap_bcd_q;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (lap_bcd_q[4*d +: 4] == 4'd9) begin
          lap_inc_d[4*d +: 4] = 4'd0;
        end else begin
          lap_inc_d[4*d +: 4] = lap_bcd_q[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lap_bcd_q   <= '0;
      lap_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      run_stop_q  <= 1'b0;
    end else begin
      lap_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.clear_i && bus.start_i) begin
            state_q   <= RUN;
            lap_bcd_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (bus.clear_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (lap_evt) begin
            lap_pulse_q <= 1'b1;
            if (lap_inc_d == MAX_BCD) begin
`ifdef SNAKE_LAP_WRAP_EN
              lap_bcd_q  <= '0;
`else
              lap_bcd_q  <= lap_inc_d;
              state_q    <= DONE;
              busy_q     <= 1'b0;
              run_stop_q <= 1'b1;
`endif
            end else begin
              lap_bcd_q <= lap_inc_d;
            end
          end
        end
        DONE: begin
          if (bus.clear_i) begin
            state_q    <= IDLE;
            run_stop_q <= 1'b0;
          end else if (bus.start_i) begin
            state_q    <= RUN;
            lap_bcd_q  <= '0;
            busy_q     <= 1'b1;
            run_stop_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          run_stop_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lap_bcd_o   = lap_bcd_q;
  assign bus.lap_pulse_o = lap_pulse_q;
  assign bus.busy_o      = busy_q;
  assign bus.run_stop_o  = run_stop_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_lap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_lap_ctrl : directed vector bench for snake_lap_ctrl (MAX_LAPS 9 and 12).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_snake_lap_ctrl;

`ifdef SNAKE_LAP_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_lap_ctrl_if #(.PTN_W(5), .DIGITS(2)) a_if ();
  snake_lap_ctrl_if #(.PTN_W(5), .DIGITS(2)) b_if ();

  snake_lap_ctrl #(.PTN_LEN(8), .PTN_W(5), .DIGITS(2), .MAX_LAPS(9)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  snake_lap_ctrl #(.PTN_LEN(8), .PTN_W(5), .DIGITS(2), .MAX_LAPS(12)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  typedef struct {
    logic       start;
    logic       clear;
    logic       updn;
    logic       tick;
    logic [4:0] cnt;
    logic [7:0] bcd;
    logic       pulse;
    logic       busy;
    logic       stop;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input int s, input int c, input int u, input int t, input int n,
                     input int bcd, input int p, input int b, input int r);
    vec_t v;
    v.start = s[0]; v.clear = c[0]; v.updn = u[0]; v.tick = t[0]; v.cnt = n[4:0];
    v.bcd   = bcd[7:0]; v.pulse = p[0]; v.busy = b[0]; v.stop = r[0];
    vq.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got bcd=%h pulse=%b busy=%b stop=%b, expected bcd=%h pulse=%b busy=%b stop=%b",
                  nm, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
  endtask

  function automatic logic [10:0] a_out();
    return {a_if.lap_bcd_o, a_if.lap_pulse_o, a_if.busy_o, a_if.run_stop_o};
  endfunction

  function automatic logic [10:0] b_out();
    return {b_if.lap_bcd_o, b_if.lap_pulse_o, b_if.busy_o, b_if.run_stop_o};
  endfunction

  task automatic drive_a(input logic s, input logic c, input logic u, input logic t, input logic [4:0] n);
    a_if.start_i = s; a_if.clear_i = c; a_if.updn_i = u; a_if.ptn_tick_i = t; a_if.ptn_cnt_i = n;
  endtask

  task automatic a_tick(input logic u, input logic [4:0] n);
    drive_a(1'b0, 1'b0, u, 1'b1, n);
    cyc();
    a_if.ptn_tick_i = 1'b0;
  endtask

  task automatic b_tick(input logic u, input logic [4:0] n);
    b_if.start_i = 1'b0; b_if.clear_i = 1'b0; b_if.updn_i = u; b_if.ptn_tick_i = 1'b1; b_if.ptn_cnt_i = n;
    cyc();
    b_if.ptn_tick_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] exp;

    drive_a(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    b_if.start_i = 1'b0; b_if.clear_i = 1'b0; b_if.updn_i = 1'b1;
    b_if.ptn_tick_i = 1'b0; b_if.ptn_cnt_i = 5'd0;

    //   s  c  u  t  n    bcd   p  b  r
    add(1, 0, 1, 0, 0,  8'h00, 0, 1, 0);
    add(0, 0, 1, 1, 0,  8'h00, 0, 1, 0);
    for (int n = 1; n <= 6; n++) add(0, 0, 1, 1, n, 8'h00, 0, 1, 0);
    add(0, 0, 1, 1, 7,  8'h01, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 7, 8'h01, 0, 1, 0);
    add(1, 0, 1, 1, 0,  8'h01, 0, 1, 0);
    add(0, 0, 0, 1, 0,  8'h02, 1, 1, 0);
    add(0, 0, 0, 1, 9,  8'h02, 0, 1, 0);
    add(0, 0, 0, 1, 31, 8'h02, 0, 1, 0);
    add(0, 0, 1, 1, 0,  8'h02, 0, 1, 0);
    add(0, 1, 0, 1, 0,  8'h02, 0, 0, 0);
    add(0, 0, 0, 1, 0,  8'h02, 0, 0, 0);
    add(1, 0, 0, 0, 0,  8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 0,  8'h01, 1, 1, 0);
    add(0, 0, 0, 1, 0,  8'h02, 1, 1, 0);

    #12;
    chk("reset_a", a_out(), 11'h000);
    chk("reset_b", b_out(), 11'h000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive_a(vq[i].start, vq[i].clear, vq[i].updn, vq[i].tick, vq[i].cnt);
      cyc();
      chk($sformatf("vec%0d", i), a_out(), {vq[i].bcd, vq[i].pulse, vq[i].busy, vq[i].stop});
    end

    // Descending laps up to the terminal count.
    for (int lap = 3; lap <= 9; lap++) begin
      for (int n = 7; n >= 1; n--) a_tick(1'b0, 5'(n));
      a_tick(1'b0, 5'd0);
      if (lap == 9) exp = WRAP ? {8'h00, 1'b1, 1'b1, 1'b0} : {8'h09, 1'b1, 1'b0, 1'b1};
      else          exp = {8'(lap), 1'b1, 1'b1, 1'b0};
      chk($sformatf("down_lap%0d", lap), a_out(), exp);
    end

    for (int n = 7; n >= 1; n--) a_tick(1'b0, 5'(n));
    a_tick(1'b0, 5'd0);
    chk("after_terminal", a_out(), WRAP ? {8'h01, 1'b1, 1'b1, 1'b0} : {8'h09, 1'b0, 1'b0, 1'b1});

    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("clear_start", a_out(), {(WRAP ? 8'h01 : 8'h09), 1'b0, 1'b0, 1'b0});

    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    cyc();
    chk("restart", a_out(), {8'h00, 1'b0, 1'b1, 1'b0});
    cyc();
    chk("start_held", a_out(), {8'h00, 1'b0, 1'b1, 1'b0});
    a_if.start_i = 1'b0;

    for (int k = 0; k < 4; k++) a_tick(1'b0, 5'd0);
    chk("lap4", a_out(), {8'h04, 1'b1, 1'b1, 1'b0});
    a_tick(1'b0, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", a_out(), 11'h000);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_idle", a_out(), 11'h000);

    // Second instance: two-digit carry and terminal at 12.
    b_if.start_i = 1'b1;
    cyc();
    chk("b_start", b_out(), {8'h00, 1'b0, 1'b1, 1'b0});
    b_if.start_i = 1'b0;
    for (int lap = 1; lap <= 12; lap++) begin
      b_tick(1'b1, 5'd7);
      if (lap == 12) exp = WRAP ? {8'h00, 1'b1, 1'b1, 1'b0} : {8'h12, 1'b1, 1'b0, 1'b1};
      else           exp = {4'(lap / 10), 4'(lap % 10), 1'b1, 1'b1, 1'b0};
      chk($sformatf("b_lap%0d", lap), b_out(), exp);
    end
    b_if.start_i = 1'b1;
    cyc();
    chk("b_rerun", b_out(), {8'h00, 1'b0, 1'b1, 1'b0});
    b_if.start_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
